// File: rtl/wb_pkg.sv
// Shared types and helpers for the round-robin Wishbone interconnect.
//   wb_arb_state_t : arbitration FSM states (IDLE, OWNED)
//   WB_SEL_W       : byte-select width per master/slave
//   WB_DEFAULT_TIMEOUT : default stall limit before a bus error
//   rr_first_set() : first set bit of a request vector, searching upward
//                    from a start offset with wrap-around
package wb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } wb_arb_state_t;

  localparam int WB_SEL_W           = 4;
  localparam int WB_DEFAULT_TIMEOUT = 255;

  // Returns the index of the first set bit of vec[n-1:0] at or after
  // 'start' (wrapping), or n when no bit is set. Scanning from the far
  // end downward lets the closest candidate overwrite the result last.
  function automatic int unsigned rr_first_set(input logic [31:0] vec,
                                               input int unsigned n,
                                               input int unsigned start);
    int unsigned idx;
    rr_first_set = n;
    for (int i = 31; i >= 0; i--) begin
      idx = start + unsigned'(i);
      if (idx >= n) idx = idx - n;
      if ((unsigned'(i) < n) && vec[idx[4:0]]) rr_first_set = idx;
    end
  endfunction

endpackage

// File: rtl/wb_rr_interconnect_if.sv
// Bus bundle for wb_rr_interconnect.
//   i_s_* : requests from the initiators (masters) into the fabric
//   o_s_* : responses from the fabric back to the initiators
//   o_m_* : requests from the fabric out to the targets (slaves)
//   i_m_* : responses from the targets into the fabric
//   o_GNT : one-hot current grant
// Modport 'slave' is the fabric's view; 'master' is the environment's view.
interface wb_rr_interconnect_if
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_MASTERS  = 2,
  parameter int N_SLAVES   = 3
);

  logic [N_MASTERS*ADDR_WIDTH-1:0] i_s_ADDR;
  logic [N_MASTERS*DATA_WIDTH-1:0] i_s_DATA;
  logic [N_MASTERS*WB_SEL_W-1:0]   i_s_SEL;
  logic [N_MASTERS-1:0]            i_s_WE;
  logic [N_MASTERS-1:0]            i_s_STB;
  logic [N_MASTERS-1:0]            i_s_CYC;
  logic [N_MASTERS-1:0]            i_s_TAGN;
  logic [N_MASTERS*DATA_WIDTH-1:0] o_s_DATA;
  logic [N_MASTERS-1:0]            o_s_ACK;
  logic [N_MASTERS-1:0]            o_s_ERR;
  logic [N_MASTERS-1:0]            o_s_TAGN;

  logic [N_SLAVES*ADDR_WIDTH-1:0]  o_m_ADDR;
  logic [N_SLAVES*DATA_WIDTH-1:0]  o_m_DATA;
  logic [N_SLAVES*WB_SEL_W-1:0]    o_m_SEL;
  logic [N_SLAVES-1:0]             o_m_WE;
  logic [N_SLAVES-1:0]             o_m_TAGN;
  logic [N_SLAVES-1:0]             o_m_STB;
  logic [N_SLAVES-1:0]             o_m_CYC;
  logic [N_SLAVES*DATA_WIDTH-1:0]  i_m_DATA;
  logic [N_SLAVES-1:0]             i_m_ACK;
  logic [N_SLAVES-1:0]             i_m_TAGN;

  logic [N_MASTERS-1:0]            o_GNT;

  modport slave (
    input  i_s_ADDR, i_s_DATA, i_s_SEL, i_s_WE, i_s_STB, i_s_CYC, i_s_TAGN,
    output o_s_DATA, o_s_ACK, o_s_ERR, o_s_TAGN,
    output o_m_ADDR, o_m_DATA, o_m_SEL, o_m_WE, o_m_TAGN, o_m_STB, o_m_CYC,
    input  i_m_DATA, i_m_ACK, i_m_TAGN,
    output o_GNT
  );

  modport master (
    output i_s_ADDR, i_s_DATA, i_s_SEL, i_s_WE, i_s_STB, i_s_CYC, i_s_TAGN,
    input  o_s_DATA, o_s_ACK, o_s_ERR, o_s_TAGN,
    input  o_m_ADDR, o_m_DATA, o_m_SEL, o_m_WE, o_m_TAGN, o_m_STB, o_m_CYC,
    output i_m_DATA, i_m_ACK, i_m_TAGN,
    input  o_GNT
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter with a remembered last winner.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : request vector (one bit per initiator)
//   i_en           : arbitration enable; a grant taken while enabled
//                    becomes the new last winner
//   o_gnt, o_idx   : combinational one-hot winner and its index
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] r_last;
  int unsigned   w_start;
  int unsigned   w_pick;

  always_comb begin
    w_start = ((32'(r_last) + 1) >= unsigned'(N)) ? 0 : (32'(r_last) + 1);
    w_pick  = rr_first_set(32'(i_req), unsigned'(N), w_start);
    o_gnt   = '0;
    o_idx   = '0;
    if (w_pick < unsigned'(N)) begin
      o_idx        = w_pick[IW-1:0];
      o_gnt[o_idx] = 1'b1;
    end
  end

  // The winner owns the bus until its CYC drops, so recording it at grant
  // time is equivalent to recording it at the end of the burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= IW'(N - 1);
    end else if (i_en && (|o_gnt)) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/wb_rr_interconnect.sv
// Wishbone shared-bus interconnect: N_MASTERS initiators share one path to
// N_SLAVES targets under round-robin arbitration. Targets are selected by
// base/mask decode (lowest index wins on overlap). Unmapped accesses get a
// registered one-cycle ERR per strobe; a target stalling TIMEOUT cycles
// gets a one-cycle ERR with its strobe masked in that cycle.
//   i_CLK : clock
//   i_RST : asynchronous active-low reset
//   bus   : wb_rr_interconnect_if.slave (all request/response signals, o_GNT)
module wb_rr_interconnect
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_MASTERS  = 2,
  parameter int N_SLAVES   = 3,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT    = WB_DEFAULT_TIMEOUT
) (
  input logic                 i_CLK,
  input logic                 i_RST,
  wb_rr_interconnect_if.slave bus
);

  localparam int MIW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SIW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  wb_arb_state_t        r_state, w_next;
  logic [N_MASTERS-1:0] r_gnt;
  logic [MIW-1:0]       r_idx;
  logic [N_MASTERS-1:0] r_err_vec;
  logic [CW-1:0]        r_to_cnt;

  logic [N_MASTERS-1:0] w_arb_gnt;
  logic [MIW-1:0]       w_arb_idx;
  logic                 w_owned;
  logic                 w_cyc, w_stb, w_we, w_tagn, w_req;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [WB_SEL_W-1:0]  w_bsel;
  logic                 w_hit_any;
  logic [SIW-1:0]       w_slv;
  logic                 w_slv_ack;
  logic                 w_to_fire;
  logic [N_MASTERS-1:0] w_ack_vec;

  wb_rr_arbiter #(.N(N_MASTERS)) u_arb (
    .i_clk   (i_CLK),
    .i_rst_n (i_RST),
    .i_req   (bus.i_s_CYC),
    .i_en    (r_state == IDLE),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx)
  );

  assign w_owned = (r_state == OWNED);
  assign w_cyc   = bus.i_s_CYC[r_idx];
  assign w_stb   = bus.i_s_STB[r_idx];
  assign w_we    = bus.i_s_WE[r_idx];
  assign w_tagn  = bus.i_s_TAGN[r_idx];
  assign w_addr  = bus.i_s_ADDR[r_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata = bus.i_s_DATA[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_bsel  = bus.i_s_SEL[r_idx*WB_SEL_W +: WB_SEL_W];
  assign w_req   = w_owned && w_cyc && w_stb;

  // Downward scan so the lowest matching slave is the one left selected.
  always_comb begin
    w_hit_any = 1'b0;
    w_slv     = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((w_addr & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit_any = 1'b1;
        w_slv     = SIW'(k);
      end
    end
  end

  assign w_slv_ack = w_owned && w_cyc && w_hit_any && bus.i_m_ACK[w_slv];
  assign w_to_fire = w_req && w_hit_any && (r_to_cnt == CW'(TIMEOUT));

  // FSM: state register
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|w_arb_gnt) w_next = OWNED;
      OWNED:   if (!w_cyc)     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_gnt <= '0;
      r_idx <= '0;
    end else if ((r_state == IDLE) && (|w_arb_gnt)) begin
      r_gnt <= w_arb_gnt;
      r_idx <= w_arb_idx;
    end else if (w_owned && !w_cyc) begin
      r_gnt <= '0;
    end
  end

  // Any break in the stall (ACK, STB low, miss, leaving OWNED) restarts it.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_to_cnt <= '0;
    end else if (!w_req || !w_hit_any || w_slv_ack || w_to_fire) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + CW'(1);
    end
  end

  // One registered error per unmapped strobe cycle.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) r_err_vec <= '0;
    else        r_err_vec <= (w_req && !w_hit_any) ? r_gnt : '0;
  end

  // Request path: broadcast the owner's fields, strobe only the decoded slave.
  always_comb begin
    bus.o_m_ADDR = '0;
    bus.o_m_DATA = '0;
    bus.o_m_SEL  = '0;
    bus.o_m_WE   = '0;
    bus.o_m_TAGN = '0;
    bus.o_m_CYC  = '0;
    bus.o_m_STB  = '0;
    if (w_owned) begin
      for (int k = 0; k < N_SLAVES; k++) begin
        bus.o_m_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH] = w_addr;
        bus.o_m_DATA[k*DATA_WIDTH +: DATA_WIDTH] = w_wdata;
        bus.o_m_SEL[k*WB_SEL_W +: WB_SEL_W]      = w_bsel;
        bus.o_m_WE[k]                            = w_we;
        bus.o_m_TAGN[k]                          = w_tagn;
      end
      if (w_cyc && w_hit_any) begin
        bus.o_m_CYC[w_slv] = 1'b1;
        bus.o_m_STB[w_slv] = w_stb && !w_to_fire;
      end
    end
  end

  // Return path: only the owner sees the decoded slave's response.
  always_comb begin
    bus.o_s_DATA = '0;
    bus.o_s_TAGN = '0;
    w_ack_vec    = '0;
    if (w_owned && w_cyc && w_hit_any) begin
      bus.o_s_DATA[r_idx*DATA_WIDTH +: DATA_WIDTH] =
        bus.i_m_DATA[w_slv*DATA_WIDTH +: DATA_WIDTH];
      bus.o_s_TAGN[r_idx] = bus.i_m_TAGN[w_slv];
      w_ack_vec[r_idx]    = w_slv_ack;
    end
  end

  assign bus.o_s_ACK = w_ack_vec;
  // ACK takes priority over a coincident error.
  assign bus.o_s_ERR = (r_err_vec | (w_to_fire ? r_gnt : '0)) & ~w_ack_vec;
  assign bus.o_GNT   = r_gnt;

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Directed testbench for wb_rr_interconnect: reset, single read, round-robin
// alternation, unmapped error, timeout error, mid-burst reset, overlapping decode.
module tb_wb_rr_interconnect;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   rem [2];

  always #5 clk = ~clk;

  wb_rr_interconnect_if bus ();
  wb_rr_interconnect_if bus2 ();

  wb_rr_interconnect dut (
    .i_CLK (clk),
    .i_RST (rst_n),
    .bus   (bus)
  );

  // Slave 1 decodes the whole space; slave 0 overlaps it at 0x0xxx_xxxx.
  wb_rr_interconnect #(
    .SLAVE_BASE ({32'h2000_0000, 32'h0000_0000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hF000_0000, 32'h0000_0000, 32'hF000_0000})
  ) dut2 (
    .i_CLK (clk),
    .i_RST (rst_n),
    .bus   (bus2)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb,
                       input logic we, input logic [31:0] addr);
    bus.i_s_CYC[m]            = cyc;
    bus.i_s_STB[m]            = stb;
    bus.i_s_WE[m]             = we;
    bus.i_s_ADDR[m*32 +: 32]  = addr;
    bus.i_s_DATA[m*32 +: 32]  = 32'h1234_0000 + 32'(m);
    bus.i_s_SEL[m*4 +: 4]     = 4'hF;
    bus.i_s_TAGN[m]           = 1'b0;
  endtask

  task automatic raise();
    for (int m = 0; m < 2; m++)
      if (rem[m] > 0) set_m(m, 1'b1, 1'b1, 1'b0, (m == 0) ? 32'h0000_0100 : 32'h1000_0200);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_m_ACK = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010);
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_GNT !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.o_GNT); end
    checks++; if (bus.o_m_STB !== 3'b000) begin errors++; $display("FAIL reset_stb: got %b want 000", bus.o_m_STB); end
    checks++; if (bus.o_m_CYC !== 3'b000) begin errors++; $display("FAIL reset_cyc: got %b want 000", bus.o_m_CYC); end
    checks++; if (bus.o_s_ACK !== 2'b00 || bus.o_s_ERR !== 2'b00) begin errors++; $display("FAIL reset_ack_err: got ack=%b err=%b want 00", bus.o_s_ACK, bus.o_s_ERR); end
    checks++; if (bus.o_m_ADDR !== 96'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.o_m_ADDR); end
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    next_cycle();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010);
    @(negedge clk);
    checks++; if (bus.o_m_STB !== 3'b000) begin errors++; $display("FAIL read_arb_cycle_stb: got %b want 000", bus.o_m_STB); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_m_STB !== 3'b001) begin errors++; $display("FAIL read_stb: got %b want 001", bus.o_m_STB); end
    checks++; if (bus.o_GNT !== 2'b01) begin errors++; $display("FAIL read_gnt: got %b want 01", bus.o_GNT); end
    checks++; if (bus.o_m_ADDR[31:0] !== 32'h0000_0010) begin errors++; $display("FAIL read_addr: got %h want 00000010", bus.o_m_ADDR[31:0]); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_s_ACK !== 2'b00) begin errors++; $display("FAIL read_wait_ack: got %b want 00", bus.o_s_ACK); end
    next_cycle();
    bus.i_m_ACK  = 3'b001;
    bus.i_m_DATA = {32'h0, 32'h0, 32'hDEAD_BEEF};
    @(negedge clk);
    checks++; if (bus.o_s_ACK !== 2'b01) begin errors++; $display("FAIL read_ack: got %b want 01", bus.o_s_ACK); end
    checks++; if (bus.o_s_DATA[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data0: got %h want deadbeef", bus.o_s_DATA[31:0]); end
    checks++; if (bus.o_s_DATA[63:32] !== 32'h0) begin errors++; $display("FAIL read_data1: got %h want 0", bus.o_s_DATA[63:32]); end
    next_cycle();
    bus.i_m_ACK  = '0;
    bus.i_m_DATA = '0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (bus.o_m_CYC !== 3'b000) begin errors++; $display("FAIL read_cyc_drop: got %b want 000", bus.o_m_CYC); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_GNT !== 2'b00) begin errors++; $display("FAIL read_release_gnt: got %b want 00", bus.o_GNT); end
  endtask

  task automatic test_round_robin();
    int n;
    int g;
    logic [1:0] exp_g;
    do_reset();
    rem[0] = 3;
    rem[1] = 3;
    raise();
    for (int b = 0; b < 6; b++) begin
      g = b % 2;
      exp_g = 2'(1 << g);
      n = 0;
      @(negedge clk);
      while (bus.o_GNT == 2'b00 && n < 8) begin
        next_cycle();
        raise();
        @(negedge clk);
        n++;
      end
      checks++; if (bus.o_GNT !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", b, bus.o_GNT, exp_g); end
      checks++; if ($countones(bus.o_GNT) > 1) begin errors++; $display("FAIL rr_onehot[%0d]: got %b want at most one bit", b, bus.o_GNT); end
      bus.i_m_ACK  = bus.o_m_STB;
      bus.i_m_DATA = {3{32'hA5A5_0000 + 32'(b)}};
      #1;
      checks++; if (bus.o_s_ACK !== exp_g) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", b, bus.o_s_ACK, exp_g); end
      checks++; if (bus.o_s_DATA[g*32 +: 32] !== 32'hA5A5_0000 + 32'(b)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", b, bus.o_s_DATA[g*32 +: 32], 32'hA5A5_0000 + 32'(b)); end
      next_cycle();
      bus.i_m_ACK  = '0;
      bus.i_m_DATA = '0;
      set_m(g, 1'b0, 1'b0, 1'b0, 32'h0);
      rem[g] = rem[g] - 1;
      next_cycle();
      raise();
    end
    next_cycle();
  endtask

  task automatic test_unmapped();
    next_cycle();
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h5000_0000);
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_GNT !== 2'b10) begin errors++; $display("FAIL unmap_gnt: got %b want 10", bus.o_GNT); end
    checks++; if (bus.o_m_STB !== 3'b000 || bus.o_m_CYC !== 3'b000) begin errors++; $display("FAIL unmap_no_stb: got stb=%b cyc=%b want 000", bus.o_m_STB, bus.o_m_CYC); end
    checks++; if (bus.o_s_ERR !== 2'b00) begin errors++; $display("FAIL unmap_err_early: got %b want 00", bus.o_s_ERR); end
    next_cycle();
    bus.i_s_STB[1] = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_s_ERR !== 2'b10) begin errors++; $display("FAIL unmap_err: got %b want 10", bus.o_s_ERR); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_s_ERR !== 2'b00) begin errors++; $display("FAIL unmap_err_width: got %b want 00", bus.o_s_ERR); end
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
  endtask

  task automatic test_timeout();
    int early;
    next_cycle();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h2000_0004);
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_m_STB !== 3'b100) begin errors++; $display("FAIL to_stb: got %b want 100", bus.o_m_STB); end
    early = 0;
    for (int k = 1; k < 255; k++) begin
      next_cycle();
      @(negedge clk);
      if (bus.o_s_ERR !== 2'b00) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL to_early_err: got %0d err cycles want 0", early); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_s_ERR !== 2'b01) begin errors++; $display("FAIL to_err: got %b want 01", bus.o_s_ERR); end
    checks++; if (bus.o_m_STB !== 3'b000) begin errors++; $display("FAIL to_stb_mask: got %b want 000", bus.o_m_STB); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_s_ERR !== 2'b00) begin errors++; $display("FAIL to_err_width: got %b want 00", bus.o_s_ERR); end
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    next_cycle();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010);
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_m_STB !== 3'b001) begin errors++; $display("FAIL rstmid_pre_stb: got %b want 001", bus.o_m_STB); end
    bus.i_m_ACK = 3'b001;
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0000);
    #1;
    checks++; if (bus.o_s_ACK !== 2'b01) begin errors++; $display("FAIL rstmid_pre_ack: got %b want 01", bus.o_s_ACK); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_m_STB !== 3'b000 || bus.o_m_CYC !== 3'b000) begin errors++; $display("FAIL rstmid_stb_cyc: got stb=%b cyc=%b want 000", bus.o_m_STB, bus.o_m_CYC); end
    checks++; if (bus.o_s_ACK !== 2'b00 || bus.o_s_ERR !== 2'b00) begin errors++; $display("FAIL rstmid_ack_err: got ack=%b err=%b want 00", bus.o_s_ACK, bus.o_s_ERR); end
    checks++; if (bus.o_GNT !== 2'b00) begin errors++; $display("FAIL rstmid_gnt: got %b want 00", bus.o_GNT); end
    checks++; if (bus.o_m_ADDR !== 96'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", bus.o_m_ADDR); end
    bus.i_m_ACK = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_GNT !== 2'b01) begin errors++; $display("FAIL rstmid_first_winner: got %b want 01", bus.o_GNT); end
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_overlap();
    next_cycle();
    bus2.i_s_CYC  = 2'b01;
    bus2.i_s_STB  = 2'b01;
    bus2.i_s_ADDR = {32'h0, 32'h0000_0010};
    next_cycle();
    @(negedge clk);
    checks++; if (bus2.o_m_STB !== 3'b001) begin errors++; $display("FAIL overlap_lowest: got %b want 001", bus2.o_m_STB); end
    bus2.i_s_ADDR[31:0] = 32'h1000_0000;
    #1;
    checks++; if (bus2.o_m_STB !== 3'b010) begin errors++; $display("FAIL overlap_only_s1: got %b want 010", bus2.o_m_STB); end
    bus2.i_s_CYC = 2'b00;
    bus2.i_s_STB = 2'b00;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    bus.i_s_ADDR = '0; bus.i_s_DATA = '0; bus.i_s_SEL = '0; bus.i_s_WE = '0;
    bus.i_s_STB  = '0; bus.i_s_CYC  = '0; bus.i_s_TAGN = '0;
    bus.i_m_DATA = '0; bus.i_m_ACK  = '0; bus.i_m_TAGN = '0;
    bus2.i_s_ADDR = '0; bus2.i_s_DATA = '0; bus2.i_s_SEL = '0; bus2.i_s_WE = '0;
    bus2.i_s_STB  = '0; bus2.i_s_CYC  = '0; bus2.i_s_TAGN = '0;
    bus2.i_m_DATA = '0; bus2.i_m_ACK  = '0; bus2.i_m_TAGN = '0;
    rem[0] = 0;
    rem[1] = 0;
    test_reset();
    test_read();
    test_round_robin();
    test_unmapped();
    test_timeout();
    test_reset_mid_burst();
    test_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
